// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator with FND scan.
// Contents:
//   op_e       operator codes carried on i_selOperator
//   state_e    calculator control states
//   SEG_BLANK  all segments dark (active-low)
//   SEG_DASH   only segment g lit, used for minus sign and error display
//   bcd_to_seg one BCD digit -> active-low segment pattern {dp,g,f,e,d,c,b,a}
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      DIV  = 3'd2,
      CONV = 3'd3,
      DONE = 3'd4
   } state_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Decimal point (bit 7) is always left dark.
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] i_bcd);
      logic [7:0] r_seg;
      case (i_bcd)
         4'd0:    r_seg = 8'hC0;
         4'd1:    r_seg = 8'hF9;
         4'd2:    r_seg = 8'hA4;
         4'd3:    r_seg = 8'hB0;
         4'd4:    r_seg = 8'h99;
         4'd5:    r_seg = 8'h92;
         4'd6:    r_seg = 8'h82;
         4'd7:    r_seg = 8'hF8;
         4'd8:    r_seg = 8'h80;
         4'd9:    r_seg = 8'h90;
         default: r_seg = SEG_BLANK;
      endcase
      return r_seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_start    load i_bin and begin a conversion (takes priority over a running one)
//   i_bin      IN_W-bit unsigned value to convert
//   o_done     high in the cycle whose closing edge performs the final shift;
//              o_bcd holds the finished result from the following cycle on
//   o_bcd      DIGITS*4-bit BCD accumulator, digit 0 in the low nibble
// A conversion takes exactly IN_W shift edges after the loading edge.
module bin2bcd_seq #(
   parameter int IN_W   = 16,
   parameter int DIGITS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic [IN_W-1:0]       i_bin,
   output logic                  o_done,
   output logic [DIGITS*4-1:0]   o_bcd
);

   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(IN_W + 1);

   logic [IN_W-1:0] r_bin;
   logic [BW-1:0]   r_bcd;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic [BW-1:0]   w_adj;

   // Add 3 to every nibble that would reach 10 or more after the next shift.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) begin
            w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_bin  <= i_bin;
         r_bcd  <= '0;
         r_cnt  <= CW'(IN_W);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         // The adjusted accumulator's top bit falls off; values that would need
         // it are rejected before a conversion is ever started.
         r_bcd <= BW'({w_adj, r_bin[IN_W-1]});
         r_bin <= {r_bin[IN_W-2:0], 1'b0};
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done = r_busy && (r_cnt == CW'(1));
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/seq_calc_fnd_scan.sv
// Sequential calculator (add / |sub| / mul / div) driving a multiplexed
// seven-segment display with sign, error dashes and leading-zero blanking.
// Ports:
//   i_clk, i_reset_n   clock (rising) and asynchronous active-low reset
//   i_a, i_b           unsigned WIDTH-bit operands, latched on an accepted start
//   i_selOperator      00 add, 01 sub, 10 mul, 11 div (quotient)
//   i_start            one-cycle request, only honoured while idle
//   i_en               display enable, 0 darkens every digit
//   o_busy             high from the cycle after an accepted start through DONE
//   o_valid            one-cycle pulse in DONE
//   o_err              overflow / divide-by-zero of the most recent operation
//   o_digit            active-low one-hot digit select
//   o_fndFont          active-low segments {dp,g,f,e,d,c,b,a}
// Handshake: a start is accepted on the rising edge where the block is idle
// and i_start is high; operands are captured on that same edge and later input
// changes or start pulses have no effect until o_valid has been given.
module seq_calc_fnd_scan
   import calc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic [WIDTH-1:0]    i_a,
   input  logic [WIDTH-1:0]    i_b,
   input  logic [1:0]          i_selOperator,
   input  logic                i_start,
   input  logic                i_en,
   output logic                o_busy,
   output logic                o_valid,
   output logic                o_err,
   output logic [DIGITS-1:0]   o_digit,
   output logic [7:0]          o_fndFont
);

   localparam int          MW       = 2 * WIDTH;
   localparam int          BW       = DIGITS * 4;
   localparam int          DCW      = $clog2(WIDTH + 1);
   localparam int          IW       = $clog2(DIGITS);
   localparam int          SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [63:0] MAX_MAG  = 64'(10**DIGITS - 1);
   localparam logic [63:0] NEG_LIM  = 64'(10**(DIGITS - 1));

   // Reset is applied asynchronously but released only on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   state_e             r_state, w_next;
   logic [WIDTH-1:0]   r_a, r_b;
   op_e                r_op;
   logic               r_neg_res, r_err_res;
   logic [WIDTH-1:0]   r_rem, r_quo;
   logic [DCW-1:0]     r_div_cnt;
   logic [BW-1:0]      r_disp_bcd;
   logic               r_disp_neg, r_disp_err;

   logic [MW-1:0]      w_mag;
   logic               w_neg, w_calc_err;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_next, w_quo_next;
   logic               w_div_last, w_quo_ovf;
   logic               w_conv_start, w_conv_done;
   logic [MW-1:0]      w_conv_in;
   logic [BW-1:0]      w_conv_bcd;

   // One-cycle arithmetic on the latched operands; sub yields a magnitude plus sign.
   always_comb begin
      w_mag = '0;
      w_neg = 1'b0;
      case (r_op)
         OP_ADD: w_mag = MW'(r_a) + MW'(r_b);
         OP_SUB: begin
            if (r_b > r_a) begin
               w_neg = 1'b1;
               w_mag = MW'(r_b - r_a);
            end else begin
               w_mag = MW'(r_a - r_b);
            end
         end
         OP_MUL: w_mag = MW'(r_a) * MW'(r_b);
         default: w_mag = '0;
      endcase
   end

   // A negative result needs one digit position free for the dash.
   assign w_calc_err = (r_op == OP_DIV) ? (r_b == '0)
                     : ((64'(w_mag) > MAX_MAG) || (w_neg && (64'(w_mag) >= NEG_LIM)));

   // Restoring divider step: shift next dividend bit into the remainder,
   // subtract the divisor when it fits.
   assign w_shift    = {r_rem, r_quo[WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_b});
   assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_b}) : w_shift[WIDTH-1:0];
   assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};
   assign w_div_last = (r_div_cnt == DCW'(1));
   assign w_quo_ovf  = (64'(w_quo_next) > MAX_MAG);

   // The converter is loaded on the same edge the FSM enters CONV.
   assign w_conv_start = ((r_state == CALC) && (r_op != OP_DIV) && !w_calc_err)
                       || ((r_state == DIV) && w_div_last && !w_quo_ovf);
   assign w_conv_in    = (r_state == DIV) ? {{WIDTH{1'b0}}, w_quo_next} : w_mag;

   bin2bcd_seq #(
      .IN_W   (MW),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .i_clk     (i_clk),
      .i_reset_n (w_rst_n),
      .i_start   (w_conv_start),
      .i_bin     (w_conv_in),
      .o_done    (w_conv_done),
      .o_bcd     (w_conv_bcd)
   );

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      o_busy  = 1'b0;
      o_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) w_next = CALC;
         end
         CALC: begin
            o_busy = 1'b1;
            if (w_calc_err)             w_next = DONE;
            else if (r_op == OP_DIV)    w_next = DIV;
            else                        w_next = CONV;
         end
         DIV: begin
            o_busy = 1'b1;
            if (w_div_last) w_next = w_quo_ovf ? DONE : CONV;
         end
         CONV: begin
            o_busy = 1'b1;
            if (w_conv_done) w_next = DONE;
         end
         DONE: begin
            o_busy  = 1'b1;
            o_valid = 1'b1;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_a        <= '0;
         r_b        <= '0;
         r_op       <= OP_ADD;
         r_neg_res  <= 1'b0;
         r_err_res  <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_div_cnt  <= '0;
         r_disp_bcd <= '0;
         r_disp_neg <= 1'b0;
         r_disp_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_a  <= i_a;
                  r_b  <= i_b;
                  r_op <= op_e'(i_selOperator);
               end
            end
            CALC: begin
               r_neg_res <= w_neg;
               r_err_res <= w_calc_err;
               r_rem     <= '0;
               r_quo     <= r_a;
               r_div_cnt <= DCW'(WIDTH);
            end
            DIV: begin
               r_rem     <= w_rem_next;
               r_quo     <= w_quo_next;
               r_div_cnt <= r_div_cnt - DCW'(1);
               if (w_div_last) r_err_res <= w_quo_ovf;
            end
            DONE: begin
               r_disp_bcd <= r_err_res ? '0 : w_conv_bcd;
               r_disp_neg <= r_neg_res && !r_err_res;
               r_disp_err <= r_err_res;
            end
            default: ;
         endcase
      end
   end

   // During DONE the fresh error flag is shown so it lines up with o_valid.
   assign o_err = (r_state == DONE) ? r_err_res : r_disp_err;

   // Display scan
   logic [SCW-1:0]    r_scan_cnt;
   logic [IW-1:0]     r_scan_idx;
   logic [DIGITS-1:0] r_digit, w_digit;
   logic [7:0]        r_font, w_font;
   logic [IW-1:0]     w_msd;
   logic [3:0]        w_cur;

   // Highest nonzero digit; digit 0 counts even when zero so it is always lit.
   always_comb begin
      w_msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_disp_bcd[i*4 +: 4] != 4'd0) w_msd = IW'(i);
      end
   end

   assign w_cur = r_disp_bcd[int'(r_scan_idx)*4 +: 4];

   always_comb begin
      w_digit = '1;
      w_font  = SEG_BLANK;
      if (i_en) begin
         w_digit = ~(DIGITS'(1) << r_scan_idx);
         if (r_disp_err)                                   w_font = SEG_DASH;
         else if (int'(r_scan_idx) <= int'(w_msd))         w_font = bcd_to_seg(w_cur);
         else if (r_disp_neg && (int'(r_scan_idx) == int'(w_msd) + 1)) w_font = SEG_DASH;
      end
   end

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
         r_digit    <= '1;
         r_font     <= SEG_BLANK;
      end else begin
         if (r_scan_cnt == SCW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IW'(DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
         end else begin
            r_scan_cnt <= r_scan_cnt + SCW'(1);
         end
         r_digit <= w_digit;
         r_font  <= w_font;
      end
   end

   assign o_digit   = r_digit;
   assign o_fndFont = r_font;

endmodule

// File: tb/tb_seq_calc_fnd_scan.sv
// Bench for seq_calc_fnd_scan (WIDTH=8, DIGITS=4, SCAN_DIV=4).
// Expected results come from a decimal-arithmetic model of the calculator and
// display; each issued operation pushes its expectation into exp_q and the
// DONE observation pops it.
module tb_seq_calc_fnd_scan;

   localparam int WIDTH    = 8;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [WIDTH-1:0]   i_a = '0;
   logic [WIDTH-1:0]   i_b = '0;
   logic [1:0]         i_sel = 2'b00;
   logic               i_start = 1'b0;
   logic               i_en = 1'b1;
   logic               o_busy, o_valid, o_err;
   logic [DIGITS-1:0]  o_digit;
   logic [7:0]         o_fndFont;

   int checks = 0;
   int failures = 0;
   logic [32:0] exp_q[$];

   seq_calc_fnd_scan #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_a           (i_a),
      .i_b           (i_b),
      .i_selOperator (i_sel),
      .i_start       (i_start),
      .i_en          (i_en),
      .o_busy        (o_busy),
      .o_valid       (o_valid),
      .o_err         (o_err),
      .o_digit       (o_digit),
      .o_fndFont     (o_fndFont)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

   // Scoreboard helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Four fonts {digit3,digit2,digit1,digit0} as a person would write the number.
   function automatic logic [31:0] fonts_of(input bit err, input bit neg, input int mag);
      logic [31:0] f;
      int nd, t, pw;
      nd = 1;
      t = mag / 10;
      while (t > 0) begin
         nd++;
         t = t / 10;
      end
      pw = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (err)               f[i*8 +: 8] = 8'hBF;
         else if (i < nd)       f[i*8 +: 8] = seg_of((mag / pw) % 10);
         else if (neg && i == nd) f[i*8 +: 8] = 8'hBF;
         else                   f[i*8 +: 8] = 8'hFF;
         pw = pw * 10;
      end
      return f;
   endfunction

   function automatic logic [32:0] model(input int a, input int b, input int op, output int lat);
      int mag;
      bit neg, err;
      mag = 0;
      neg = 1'b0;
      err = 1'b0;
      case (op)
         0: mag = a + b;
         1: begin
            if (b > a) begin neg = 1'b1; mag = b - a; end
            else mag = a - b;
         end
         2: mag = a * b;
         default: begin
            if (b == 0) err = 1'b1;
            else mag = a / b;
         end
      endcase
      if (mag > 9999) err = 1'b1;
      if (neg && mag >= 1000) err = 1'b1;
      if (err)          lat = 2;
      else if (op == 3) lat = 3 * WIDTH + 2;
      else              lat = 2 * WIDTH + 2;
      return {err, fonts_of(err, neg, mag)};
   endfunction

   // Driver / monitor tasks
   task automatic check_display(input logic [31:0] fonts);
      int idx, zeros;
      logic [3:0] seen;
      seen = '0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4 * SCAN_DIV; s++) begin
         @(negedge clk);
         zeros = 0;
         idx = 0;
         for (int i = 0; i < DIGITS; i++) begin
            if (o_digit[i] == 1'b0) begin zeros++; idx = i; end
         end
         check("digit_one_hot_low", zeros, 1);
         if (zeros == 1) begin
            check($sformatf("font_digit%0d", idx), o_fndFont, fonts[idx*8 +: 8]);
            seen[idx] = 1'b1;
         end
      end
      check("all_digits_scanned", seen, 4'hF);
   endtask

   task automatic check_scan_order(output bit any_valid);
      int prev, run, idx, changes;
      prev = -1;
      run = 0;
      changes = 0;
      any_valid = 1'b0;
      for (int s = 0; s < 6 * SCAN_DIV; s++) begin
         @(negedge clk);
         if (o_valid) any_valid = 1'b1;
         idx = -1;
         for (int i = 0; i < DIGITS; i++) if (o_digit[i] == 1'b0) idx = i;
         if (prev < 0) begin
            prev = idx;
            run = 1;
         end else if (idx == prev) begin
            run++;
         end else begin
            check("scan_next_index", idx, (prev + 1) % DIGITS);
            if (changes > 0) check("scan_hold_cycles", run, SCAN_DIV);
            changes++;
            prev = idx;
            run = 1;
         end
      end
      check("scan_advanced", (changes >= 4) ? 1 : 0, 1);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input bit poke);
      logic [32:0] e_val;
      int lat, n;
      bit got;
      exp_q.push_back(model(int'(a), int'(b), int'(op), lat));
      @(negedge clk);
      i_a = a;
      i_b = b;
      i_sel = op;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (poke && n == 3) begin
            i_a = ~a;
            i_b = b ^ 8'h5A;
            i_sel = op + 2'd1;
            i_start = 1'b1;
         end
         if (poke && n == 4) i_start = 1'b0;
         if (o_valid) got = 1'b1;
      end
      i_start = 1'b0;
      e_val = exp_q.pop_front();
      check("valid_seen", 32'(got), 1);
      if (got) begin
         check("latency", n, lat);
         check("err_at_valid", 32'(o_err), 32'(e_val[32]));
         check("busy_at_valid", 32'(o_busy), 1);
         @(negedge clk);
         check("valid_one_cycle", 32'(o_valid), 0);
         check("busy_cleared", 32'(o_busy), 0);
         check("err_held", 32'(o_err), 32'(e_val[32]));
         check_display(e_val[31:0]);
      end
   endtask

   // Directed and random sequence
   initial begin
      bit v;
      int lat0;
      logic [32:0] zero_disp;
      logic [1:0]  rop;
      logic [7:0]  ra, rb;

      repeat (3) @(negedge clk);
      check("reset_busy", 32'(o_busy), 0);
      check("reset_valid", 32'(o_valid), 0);
      check("reset_err", 32'(o_err), 0);
      check("reset_digit", 32'(o_digit), 32'hF);
      check("reset_font", 32'(o_fndFont), 32'hFF);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_scan_order(v);
      check("no_valid_when_idle", 32'(v), 0);

      run_op(8'd200, 8'd55, 2'b00, 1'b0);
      run_op(8'd3, 8'd10, 2'b01, 1'b0);
      run_op(8'd200, 8'd100, 2'b10, 1'b0);
      run_op(8'd200, 8'd7, 2'b11, 1'b0);
      run_op(8'd5, 8'd0, 2'b11, 1'b0);
      run_op(8'd12, 8'd34, 2'b00, 1'b1);
      run_op(8'd0, 8'd0, 2'b00, 1'b0);
      run_op(8'd99, 8'd101, 2'b10, 1'b0);

      // Abort in the middle of a conversion.
      @(negedge clk);
      i_a = 8'd200;
      i_b = 8'd55;
      i_sel = 2'b00;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(o_busy), 0);
      check("abort_valid", 32'(o_valid), 0);
      check("abort_err", 32'(o_err), 0);
      check("abort_digit", 32'(o_digit), 32'hF);
      check("abort_font", 32'(o_fndFont), 32'hFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_scan_order(v);
      check("no_valid_after_abort", 32'(v), 0);
      zero_disp = model(0, 0, 0, lat0);
      check_display(zero_disp[31:0]);

      // Display disabled: dark, while the scan keeps running.
      i_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4 * SCAN_DIV; s++) begin
         @(negedge clk);
         check("dark_digit", 32'(o_digit), 32'hF);
         check("dark_font", 32'(o_fndFont), 32'hFF);
      end
      i_en = 1'b1;

      for (int k = 0; k < 12; k++) begin
         rop = 2'($urandom_range(0, 3));
         ra = 8'($urandom_range(0, 255));
         if (rop == 2'b11)      rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         else if (rop == 2'b10) rb = 8'($urandom_range(0, 60));
         else                   rb = 8'($urandom_range(0, 255));
         run_op(ra, rb, rop, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
